// File: rtl/copro_mailbox_09.sv
// 6809-side mailbox: two byte FIFOs (host->6809, 6809->host), four bus registers, and an
// active-low IRQ. Bus accesses are captured while E is high and commit on the first E-low clock.
module copro_mailbox_09 #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_e,
  input  logic       sel_09,
  input  logic [1:0] address_09,
  input  logic       r_w_09,
  input  logic [7:0] data_09_in,
  output logic [7:0] data_09_out,
  output logic       data_09_oe,
  input  logic       host_wr,
  input  logic [7:0] host_data_in,
  input  logic       host_rd,
  output logic [7:0] host_data_out,
  output logic       h2c_full,
  output logic       c2h_empty,
  output logic       _irq_09
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [7:0]    h2c_mem_q [DEPTH];
  logic [7:0]    c2h_mem_q [DEPTH];
  logic [AW-1:0] h2c_wp_q, h2c_rp_q, c2h_wp_q, c2h_rp_q;
  logic [CW-1:0] h2c_cnt_q, c2h_cnt_q, h2c_cnt_d, c2h_cnt_d;
  logic          h2c_ovf_q, c2h_ovf_q, h2c_ovf_d, c2h_ovf_d;
  logic [1:0]    en_q;
  logic          e_q, sel_r_q, rw_r_q, irq_n_q;
  logic [1:0]    addr_r_q;
  logic [7:0]    din_r_q, dout_q;

  logic       window, commit, clr_ovf;
  logic       h2c_do_push, h2c_do_pop, c2h_do_push, c2h_do_pop;
  logic       h2c_ne, c2h_ne, irq_pending;
  logic [7:0] h2c_head, rd_data;

  assign window   = clock_e & sel_09;
  // Falling E with a captured select: the single commit point of each E cycle.
  assign commit   = e_q & ~clock_e & sel_r_q;
  assign h2c_ne   = (h2c_cnt_q != '0);
  assign c2h_ne   = (c2h_cnt_q != '0);
  assign h2c_head = h2c_ne ? h2c_mem_q[h2c_rp_q] : 8'h00;

  always_comb begin
    clr_ovf     = commit & ~rw_r_q & (addr_r_q == 2'd0);
    h2c_do_pop  = commit & rw_r_q & (addr_r_q == 2'd1) & h2c_ne;
    h2c_do_push = host_wr & ((h2c_cnt_q != CW'(DEPTH)) | h2c_do_pop);
    c2h_do_pop  = host_rd & c2h_ne;
    c2h_do_push = commit & ~rw_r_q & (addr_r_q == 2'd1) &
                  ((c2h_cnt_q != CW'(DEPTH)) | c2h_do_pop);
    // Set beats clear when both land on the same clock.
    h2c_ovf_d = (host_wr & ~h2c_do_push) | (h2c_ovf_q & ~(clr_ovf & din_r_q[2]));
    c2h_ovf_d = (commit & ~rw_r_q & (addr_r_q == 2'd1) & ~c2h_do_push) |
                (c2h_ovf_q & ~(clr_ovf & din_r_q[3]));
    h2c_cnt_d = h2c_cnt_q;
    if (h2c_do_push && !h2c_do_pop) h2c_cnt_d = h2c_cnt_q + CW'(1);
    if (!h2c_do_push && h2c_do_pop) h2c_cnt_d = h2c_cnt_q - CW'(1);
    c2h_cnt_d = c2h_cnt_q;
    if (c2h_do_push && !c2h_do_pop) c2h_cnt_d = c2h_cnt_q + CW'(1);
    if (!c2h_do_push && c2h_do_pop) c2h_cnt_d = c2h_cnt_q - CW'(1);
  end

  assign irq_pending = (en_q[0] & h2c_ne) | (en_q[1] & ~c2h_ne);

  always_comb begin
    rd_data = 8'h00;
    case (address_09)
      2'd0:    rd_data = {irq_pending, 3'b000, c2h_ovf_q, h2c_ovf_q,
                          (c2h_cnt_q == CW'(DEPTH)), h2c_ne};
      2'd1:    rd_data = h2c_head;
      2'd2:    rd_data = {6'b0, en_q};
      default: rd_data = {4'(c2h_cnt_q), 4'(h2c_cnt_q)};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h2c_wp_q  <= '0;
      h2c_rp_q  <= '0;
      c2h_wp_q  <= '0;
      c2h_rp_q  <= '0;
      h2c_cnt_q <= '0;
      c2h_cnt_q <= '0;
      h2c_ovf_q <= 1'b0;
      c2h_ovf_q <= 1'b0;
      en_q      <= 2'b00;
      e_q       <= 1'b0;
      sel_r_q   <= 1'b0;
      addr_r_q  <= 2'd0;
      rw_r_q    <= 1'b0;
      din_r_q   <= 8'h00;
      dout_q    <= 8'h00;
      irq_n_q   <= 1'b1;
    end else begin
      e_q <= clock_e;
      if (clock_e) begin
        sel_r_q  <= sel_09;
        addr_r_q <= address_09;
        rw_r_q   <= r_w_09;
        din_r_q  <= data_09_in;
      end
      if (window) dout_q <= rd_data;
      if (h2c_do_push) h2c_wp_q <= h2c_wp_q + AW'(1);
      if (h2c_do_pop)  h2c_rp_q <= h2c_rp_q + AW'(1);
      if (c2h_do_push) c2h_wp_q <= c2h_wp_q + AW'(1);
      if (c2h_do_pop)  c2h_rp_q <= c2h_rp_q + AW'(1);
      h2c_cnt_q <= h2c_cnt_d;
      c2h_cnt_q <= c2h_cnt_d;
      h2c_ovf_q <= h2c_ovf_d;
      c2h_ovf_q <= c2h_ovf_d;
      if (commit && !rw_r_q && addr_r_q == 2'd2) en_q <= din_r_q[1:0];
      irq_n_q <= ~irq_pending;
    end
  end

  always_ff @(posedge clock) begin
    if (h2c_do_push) h2c_mem_q[h2c_wp_q] <= host_data_in;
    if (c2h_do_push) c2h_mem_q[c2h_wp_q] <= din_r_q;
  end

  assign data_09_oe    = window & r_w_09;
  assign data_09_out   = window ? rd_data : dout_q;
  assign host_data_out = c2h_ne ? c2h_mem_q[c2h_rp_q] : 8'h00;
  assign h2c_full      = (h2c_cnt_q == CW'(DEPTH));
  assign c2h_empty     = ~c2h_ne;
  assign _irq_09       = irq_n_q;

endmodule

// File: tb/tb_copro_mailbox_09.sv
// Directed bench for copro_mailbox_09 with a queue-based model of both FIFOs and status bits.
module tb_copro_mailbox_09;
  localparam int unsigned DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset, clock_e, sel_09, r_w_09, host_wr, host_rd;
  logic [1:0] address_09;
  logic [7:0] data_09_in, host_data_in;
  logic [7:0] data_09_out, host_data_out;
  logic       data_09_oe, h2c_full, c2h_empty, _irq_09;

  copro_mailbox_09 #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clock_e(clock_e), .sel_09(sel_09),
    .address_09(address_09), .r_w_09(r_w_09), .data_09_in(data_09_in),
    .data_09_out(data_09_out), .data_09_oe(data_09_oe), .host_wr(host_wr),
    .host_data_in(host_data_in), .host_rd(host_rd), .host_data_out(host_data_out),
    .h2c_full(h2c_full), .c2h_empty(c2h_empty), ._irq_09(_irq_09)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  logic [7:0] h2c_m[$];
  logic [7:0] c2h_m[$];
  logic       h2c_ovf_m = 1'b0, c2h_ovf_m = 1'b0;
  logic [1:0] en_m = 2'b00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_status();
    logic pend;
    pend = (en_m[0] && h2c_m.size() != 0) || (en_m[1] && c2h_m.size() == 0);
    return {pend, 3'b000, c2h_ovf_m, h2c_ovf_m, c2h_m.size() == DEPTH, h2c_m.size() != 0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic h2c_model_push(input logic [7:0] b);
    if (h2c_m.size() < DEPTH) h2c_m.push_back(b);
    else h2c_ovf_m = 1'b1;
  endtask

  task automatic host_push(input logic [7:0] b);
    host_wr = 1'b1;
    host_data_in = b;
    tick(1);
    host_wr = 1'b0;
    h2c_model_push(b);
  endtask

  task automatic host_pop(input string tag);
    logic [7:0] e;
    e = (c2h_m.size() != 0) ? c2h_m.pop_front() : 8'h00;
    chk(tag, host_data_out, e);
    host_rd = 1'b1;
    tick(1);
    host_rd = 1'b0;
  endtask

  // One E cycle: two high clocks, sample at the last high negedge, commit on the next clock.
  task automatic bus(input logic [1:0] a, input logic rw, input logic [7:0] d,
                     input logic hw, input logic [7:0] hb, output logic [7:0] q);
    clock_e = 1'b1; sel_09 = 1'b1; address_09 = a; r_w_09 = rw; data_09_in = d;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    q = data_09_out;
    chk("data_09_oe", {7'b0, data_09_oe}, {7'b0, rw});
    clock_e = 1'b0; sel_09 = 1'b0;
    if (hw) begin
      host_wr = 1'b1;
      host_data_in = hb;
    end
    tick(1);
    host_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag,
                    input logic hw = 1'b0, input logic [7:0] hb = 8'h00);
    logic [7:0] q, e;
    case (a)
      2'd0:    e = exp_status();
      2'd1:    e = (h2c_m.size() != 0) ? h2c_m[0] : 8'h00;
      2'd2:    e = {6'b0, en_m};
      default: e = {4'(c2h_m.size()), 4'(h2c_m.size())};
    endcase
    bus(a, 1'b1, 8'h00, hw, hb, q);
    chk(tag, q, e);
    if (a == 2'd1 && h2c_m.size() != 0) void'(h2c_m.pop_front());
    if (hw) h2c_model_push(hb);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus(a, 1'b0, d, 1'b0, 8'h00, q);
    case (a)
      2'd0: begin
        if (d[2]) h2c_ovf_m = 1'b0;
        if (d[3]) c2h_ovf_m = 1'b0;
      end
      2'd1: if (c2h_m.size() < DEPTH) c2h_m.push_back(d); else c2h_ovf_m = 1'b1;
      2'd2: en_m = d[1:0];
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clock_e = 1'b0; sel_09 = 1'b0; r_w_09 = 1'b0; address_09 = 2'd0;
    data_09_in = 8'h00; host_wr = 1'b0; host_rd = 1'b0; host_data_in = 8'h00;
    tick(2);
    chk("rst_irq_n", {7'b0, _irq_09}, 8'h01);
    chk("rst_c2h_empty", {7'b0, c2h_empty}, 8'h01);
    chk("rst_h2c_full", {7'b0, h2c_full}, 8'h00);
    chk("rst_host_dout", host_data_out, 8'h00);
    chk("rst_oe", {7'b0, data_09_oe}, 8'h00);
    chk("rst_dout", data_09_out, 8'h00);
    reset = 1'b0;
    tick(1);

    // Reset landing mid-E must suppress the pending DATA write.
    clock_e = 1'b1; sel_09 = 1'b1; address_09 = 2'd1; r_w_09 = 1'b0; data_09_in = 8'h77;
    tick(2);
    reset = 1'b1; clock_e = 1'b0; sel_09 = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("midE_reset_c2h_empty", {7'b0, c2h_empty}, 8'h01);
    rd(2'd0, "rst_status");
    rd(2'd3, "rst_count");

    host_push(8'h11); host_push(8'h22); host_push(8'h33);
    rd(2'd3, "count3");
    for (int i = 0; i < 3; i++) rd(2'd1, "h2c_data");
    rd(2'd3, "count0");
    rd(2'd1, "empty_data");

    for (int i = 0; i <= DEPTH; i++) host_push(8'(i));
    chk("h2c_full", {7'b0, h2c_full}, 8'h01);
    rd(2'd0, "ovf_status");
    for (int i = 0; i < DEPTH; i++) rd(2'd1, "ovf_data");
    wr(2'd0, 8'h04);
    rd(2'd0, "ovf_cleared");

    wr(2'd1, 8'hA5);
    chk("c2h_not_empty", {7'b0, c2h_empty}, 8'h00);
    host_pop("host_dout_a5");
    chk("host_dout_empty", host_data_out, 8'h00);
    chk("c2h_empty_again", {7'b0, c2h_empty}, 8'h01);

    wr(2'd2, 8'h01);
    rd(2'd2, "irq_en_rd");
    host_push(8'h5A);
    chk("irq_latency_hi", {7'b0, _irq_09}, 8'h01);
    tick(1);
    chk("irq_low", {7'b0, _irq_09}, 8'h00);
    rd(2'd0, "irq_status");
    rd(2'd1, "irq_data");
    chk("irq_still_low", {7'b0, _irq_09}, 8'h00);
    tick(1);
    chk("irq_released", {7'b0, _irq_09}, 8'h01);
    wr(2'd2, 8'h02);
    chk("irq_c2h_pre", {7'b0, _irq_09}, 8'h01);
    tick(1);
    chk("irq_c2h_low", {7'b0, _irq_09}, 8'h00);
    wr(2'd2, 8'h00);
    tick(1);
    chk("irq_off", {7'b0, _irq_09}, 8'h01);

    // Full H2C: host push on the commit clock of a DATA read.
    for (int i = 0; i < DEPTH; i++) host_push(8'h80 + 8'(i));
    rd(2'd1, "simul_data", 1'b1, 8'h99);
    rd(2'd3, "simul_count");
    rd(2'd0, "simul_status");
    for (int i = 0; i < DEPTH; i++) rd(2'd1, "simul_drain");

    for (int i = 0; i <= DEPTH; i++) wr(2'd1, 8'hC0 + 8'(i));
    wr(2'd3, 8'hFF);
    rd(2'd0, "c2h_ovf_status");
    rd(2'd3, "c2h_count");
    for (int i = 0; i < DEPTH; i++) host_pop("c2h_drain");
    chk("c2h_drained", {7'b0, c2h_empty}, 8'h01);
    wr(2'd0, 8'h08);
    rd(2'd0, "c2h_ovf_cleared");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
